inference_sequencer: RTL and testbench

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

---
 rtl/inference_sequencer.sv | 114 +++++++++++
 tb/tb_inference_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_sequencer.sv
// Sequences one image through the inference core: clear, stream NUM_PIXELS pixels (1-cycle pixel latency), await digit.
// Host pixels are backpressured by s_ready (high only while loading); results hold on r_valid until r_ready.
module inference_sequencer #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_PIXELS = 784,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont_mode,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_pixel,
  output logic                  core_rst,
  output logic                  core_i_valid,
  output logic [DATA_WIDTH-1:0] core_pixel,
  input  logic                  core_o_valid,
  input  logic [3:0]            core_digit,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [3:0]            r_digit,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [15:0]           image_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLR    = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;

  localparam int CW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] PIX_LAST = CW'(NUM_PIXELS - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [CW-1:0] pix_cnt;
  logic [TW-1:0] timer;
  logic          rst_pulse;

  assign s_ready  = (state == LOAD);
  assign r_valid  = (state == RESULT);
  assign busy     = (state != IDLE);
  // Core is held in reset by the host reset, during CLR, and for one cycle after abort/timeout.
  assign core_rst = rst | (state == CLR) | rst_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      timer        <= '0;
      rst_pulse    <= 1'b0;
      core_i_valid <= 1'b0;
      core_pixel   <= '0;
      r_digit      <= 4'd0;
      err_timeout  <= 1'b0;
      image_count  <= 16'd0;
    end else begin
      core_i_valid <= 1'b0;
      rst_pulse    <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        rst_pulse <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state       <= CLR;
              err_timeout <= 1'b0;
            end
          end
          CLR: begin
            pix_cnt <= '0;
            timer   <= '0;
            state   <= LOAD;
          end
          LOAD: begin
            if (s_valid) begin
              core_pixel   <= s_pixel;
              core_i_valid <= 1'b1;
              if (pix_cnt == PIX_LAST) state <= WAIT;
              else pix_cnt <= pix_cnt + 1'b1;
            end
          end
          WAIT: begin
            // A digit arriving on the last timer cycle still counts as a result.
            if (core_o_valid) begin
              r_digit <= core_digit;
              state   <= RESULT;
            end else if (timer == TMR_LAST) begin
              err_timeout <= 1'b1;
              rst_pulse   <= 1'b1;
              state       <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          RESULT: begin
            if (r_ready) begin
              image_count <= image_count + 16'd1;
              state       <= cont_mode ? CLR : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed-sequence bench with random pixels/digits; a queue-based pixel scoreboard checks ordering and latency.
module tb_inference_sequencer;
  localparam int DW = 24;
  localparam int NP = 784;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          rst, start, cont_mode, abort, s_valid, s_ready;
  logic [DW-1:0] s_pixel, core_pixel;
  logic          core_rst, core_i_valid, core_o_valid, r_valid, r_ready, busy, err_timeout;
  logic [3:0]    core_digit, r_digit;
  logic [15:0]   image_count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  logic [DW-1:0] pix_q[$];
  logic          xfer_d = 1'b0;

  inference_sequencer #(.DATA_WIDTH(DW), .NUM_PIXELS(NP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .cont_mode(cont_mode), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .core_rst(core_rst), .core_i_valid(core_i_valid), .core_pixel(core_pixel),
    .core_o_valid(core_o_valid), .core_digit(core_digit),
    .r_valid(r_valid), .r_ready(r_ready), .r_digit(r_digit),
    .busy(busy), .err_timeout(err_timeout), .image_count(image_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: a pixel accepted at an edge must appear on the core exactly one cycle later.
  always @(posedge clk) begin
    if (s_valid && s_ready && !abort && !rst) begin
      pix_q.push_back(s_pixel);
      xfer_d <= 1'b1;
    end else begin
      xfer_d <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("core_i_valid_latency", core_i_valid, xfer_d);
    if (xfer_d && pix_q.size() > 0) chk("core_pixel_order", core_pixel, pix_q.pop_front());
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_core_i_valid", core_i_valid, 0);
    chk("rst_core_pixel", core_pixel, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_digit", r_digit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_count", image_count, 0);
    chk("rst_core_rst", core_rst, 1);
  endtask

  task automatic start_image;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("clr_core_rst", core_rst, 1);
    chk("clr_busy", busy, 1);
    chk("clr_s_ready", s_ready, 0);
    tick;
    chk("load_entry_s_ready", s_ready, 1);
    chk("load_core_rst", core_rst, 0);
  endtask

  // mode 0: s_valid held, 1: alternating 1010..., 2: random
  task automatic load(input int n, input int mode);
    int sent = 0;
    int cyc = 0;
    while (sent < n && cyc < 20000) begin
      if (mode == 0) s_valid = 1'b1;
      else if (mode == 1) s_valid = (cyc % 2 == 0);
      else s_valid = 1'($urandom_range(0, 1));
      s_pixel = DW'($urandom);
      chk("load_s_ready", s_ready, 1);
      tick;
      if (s_valid) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    if (sent < n) chk("load_budget", sent, n);
  endtask

  task automatic wait_result(input int delay, input logic [3:0] digit, input logic cont);
    chk("wait_s_ready", s_ready, 0);
    chk("wait_busy", busy, 1);
    repeat (delay) tick;
    core_o_valid = 1'b1;
    core_digit = digit;
    tick;
    core_o_valid = 1'b0;
    chk("res_r_valid", r_valid, 1);
    chk("res_r_digit", r_digit, digit);
    chk("res_err", err_timeout, 0);
    core_o_valid = 1'b1;
    core_digit = ~digit;
    repeat (2) tick;
    core_o_valid = 1'b0;
    chk("res_hold_digit", r_digit, digit);
    chk("res_hold_valid", r_valid, 1);
    r_ready = 1'b1;
    cont_mode = cont;
    tick;
    r_ready = 1'b0;
    exp_count++;
    chk("hs_count", image_count, exp_count);
    chk("hs_r_valid", r_valid, 0);
    if (cont) begin
      chk("cont_core_rst", core_rst, 1);
      tick;
      chk("cont_load", s_ready, 1);
    end else begin
      chk("single_idle", busy, 0);
      chk("single_core_rst", core_rst, 0);
    end
  endtask

  initial begin
    logic [3:0] dig;
    rst = 1'b1; start = 1'b0; cont_mode = 1'b0; abort = 1'b0; s_valid = 1'b0;
    s_pixel = '0; core_o_valid = 1'b0; core_digit = 4'd0; r_ready = 1'b0;
    repeat (2) tick;
    chk_reset_vals;
    rst = 1'b0;
    tick;
    chk("idle_core_rst", core_rst, 0);
    chk("idle_busy", busy, 0);

    core_o_valid = 1'b1; core_digit = 4'd9;
    tick;
    core_o_valid = 1'b0;
    chk("spurious_idle_digit", r_digit, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_core_rst", core_rst, 0);

    // Single image, pixels streamed back-to-back
    start_image;
    load(NP, 0);
    wait_result(5, 4'd7, 1'b0);

    // Stalled and randomly throttled streams
    start_image;
    load(NP, 1);
    wait_result($urandom_range(0, 20), 4'($urandom), 1'b0);
    start_image;
    load(NP, 2);
    wait_result($urandom_range(0, 20), 4'($urandom), 1'b0);

    // Three images in continuous mode
    start_image;
    for (int k = 0; k < 3; k++) begin
      load(NP, 2);
      wait_result($urandom_range(0, 10), 4'($urandom), k < 2);
    end

    // Timeout, then start clears the flag, then capture on the last timer cycle
    start_image;
    load(NP, 0);
    repeat (TO - 1) tick;
    chk("to_before_err", err_timeout, 0);
    chk("to_before_busy", busy, 1);
    tick;
    chk("to_err", err_timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_core_rst", core_rst, 1);
    tick;
    chk("to_core_rst_end", core_rst, 0);
    chk("to_err_sticky", err_timeout, 1);
    start_image;
    chk("to_err_cleared", err_timeout, 0);
    load(NP, 0);
    wait_result(TO - 1, 4'd3, 1'b0);

    // Abort at pixel 400, then a full fresh image
    start_image;
    load(400, 0);
    abort = 1'b1; s_valid = 1'b1;
    tick;
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_s_ready", s_ready, 0);
    chk("abort_core_rst", core_rst, 1);
    chk("abort_idle", busy, 0);
    chk("abort_count", image_count, exp_count);
    tick;
    chk("abort_core_rst_end", core_rst, 0);
    start_image;
    load(NP, 2);
    wait_result(2, 4'd5, 1'b0);

    // Abort in RESULT wins over the handshake
    start_image;
    load(NP, 0);
    dig = 4'($urandom);
    core_o_valid = 1'b1; core_digit = dig;
    tick;
    core_o_valid = 1'b0;
    chk("res2_r_valid", r_valid, 1);
    abort = 1'b1; r_ready = 1'b1;
    tick;
    abort = 1'b0; r_ready = 1'b0;
    chk("abort_res_r_valid", r_valid, 0);
    chk("abort_res_count", image_count, exp_count);
    chk("abort_res_core_rst", core_rst, 1);
    core_o_valid = 1'b1; core_digit = ~dig;
    tick;
    core_o_valid = 1'b0;
    chk("spurious_idle_digit2", r_digit, dig);

    // Reset in the middle of a load
    start_image;
    load(100, 2);
    rst = 1'b1; s_valid = 1'b1; start = 1'b1; abort = 1'b1;
    tick;
    s_valid = 1'b0; start = 1'b0; abort = 1'b0;
    chk_reset_vals;
    rst = 1'b0;
    tick;
    chk("post_rst_busy", busy, 0);
    chk("pix_q_drained", pix_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
